// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: FSM state type and default width.
package counter_pkg;
  localparam int DEFAULT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/nbit_downcounter.sv
// Loadable N-bit down-counter: pulses done at zero, then stops or auto-reloads.
// All state updates happen on the falling edge of clk.
module nbit_downcounter
  import counter_pkg::*;
#(
  parameter int N = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         auto_reload,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  state_t       state, state_n;
  logic [N-1:0] count_n, reload_q, reload_n;
  logic         done_n;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      reload_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      reload_q <= reload_n;
      busy     <= (state_n == RUN);
      done     <= done_n;
    end
  end

  // load wins over everything, so a restart never reports the old terminal count
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_q;
    done_n   = 1'b0;
    if (load) begin
      count_n  = load_val;
      reload_n = load_val;
      if (load_val == '0) begin
        done_n  = 1'b1;
        state_n = IDLE;
      end else begin
        state_n = RUN;
      end
    end else if (state == RUN && en) begin
      if (count > N'(1)) begin
        count_n = count - N'(1);
      end else if (count == N'(1)) begin
        done_n = 1'b1;
        if (auto_reload) begin
          count_n = reload_q;
        end else begin
          count_n = '0;
          state_n = IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_nbit_downcounter.sv
// Directed self-checking bench for nbit_downcounter (N=8).
module tb_nbit_downcounter;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [N-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  nbit_downcounter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en),
    .auto_reload(auto_reload), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // advance one active (falling) edge; sample/drive 1 unit later
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] c, input logic b, input logic d);
    checks++;
    if (count !== c || busy !== b || done !== d) begin
      errors++;
      $display("FAIL %s: count=%0d busy=%b done=%b, expected count=%0d busy=%b done=%b",
               name, count, busy, done, c, b, d);
    end
  endtask

  task automatic do_load(input logic [N-1:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 0; load_val = 0; en = 0; auto_reload = 0;
    #3;
    chk("reset_initial", 0, 0, 0);
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    do_load(8'd5);
    chk("reset_preload", 5, 1, 0);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_midrun", 0, 0, 0);
    load = 1'b1; load_val = 8'd7; en = 1'b1;
    tick(); tick();
    chk("reset_held", 0, 0, 0);
    load = 1'b0; en = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("reset_release", 0, 0, 0);
  endtask

  task automatic test_oneshot();
    en = 1'b1; auto_reload = 1'b0;
    do_load(8'd3);
    chk("oneshot_load", 3, 1, 0);
    tick(); chk("oneshot_2", 2, 1, 0);
    tick(); chk("oneshot_1", 1, 1, 0);
    tick(); chk("oneshot_0_done", 0, 0, 1);
    tick(); chk("oneshot_after", 0, 0, 0);
    tick(); chk("oneshot_idle_no_wrap", 0, 0, 0);
  endtask

  task automatic test_auto_reload();
    logic [N-1:0] exp_c [8] = '{3, 2, 1, 4, 3, 2, 1, 4};
    logic         exp_d [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    en = 1'b1; auto_reload = 1'b1;
    do_load(8'd4);
    chk("auto_load", 4, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("auto_step%0d", i), exp_c[i], 1, exp_d[i]);
    end
  endtask

  task automatic test_reload_one();
    en = 1'b1; auto_reload = 1'b1;
    do_load(8'd1);
    chk("reload1_load", 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("reload1_step%0d", i), 1, 1, 1);
    end
  endtask

  task automatic test_enable();
    logic         en_seq [5] = '{1, 0, 0, 1, 1};
    logic [N-1:0] exp_c  [5] = '{4, 4, 4, 3, 2};
    auto_reload = 1'b0; en = 1'b0;
    do_load(8'd5);
    chk("enable_load", 5, 1, 0);
    for (int i = 0; i < 5; i++) begin
      en = en_seq[i];
      tick();
      chk($sformatf("enable_step%0d", i), exp_c[i], 1, 0);
    end
  endtask

  task automatic test_collision();
    auto_reload = 1'b0; en = 1'b1;
    do_load(8'd2);
    tick();
    chk("collide_at1", 1, 1, 0);
    do_load(8'd9);
    chk("collide_reload", 9, 1, 0);
    tick();
    chk("collide_continue", 8, 1, 0);
  endtask

  task automatic test_load_zero();
    en = 1'b1; auto_reload = 1'b1;
    do_load(8'd0);
    chk("zero_from_run", 0, 0, 1);
    tick();
    chk("zero_pulse_once", 0, 0, 0);
    do_load(8'd0);
    chk("zero_from_idle", 0, 0, 1);
    tick();
    chk("zero_stay_idle", 0, 0, 0);
  endtask

  task automatic test_full_scale();
    int done_at = -1;
    int ndone = 0;
    en = 1'b1; auto_reload = 1'b0;
    do_load(8'd255);
    chk("full_load", 255, 1, 0);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = i;
      end
    end
    checks++;
    if (done_at !== 255 || ndone !== 1) begin
      errors++;
      $display("FAIL full_interval: done at edge %0d (%0d pulses), expected edge 255 (1 pulse)",
               done_at, ndone);
    end
    chk("full_no_wrap", 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_reload_one();
    test_enable();
    test_collision();
    test_load_zero();
    test_full_scale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
